vga_timing_gen: RTL and testbench
=================================

// Module: vga_timing_gen
// PURPOSE
//  Generates the 640x480@60 Hz raster timing from the 25 MHz pixel clock.
//  Drives the X/Y pixel coordinates consumed by background and the other
//  pixel-decoding stages. Also drives hsync/vsync/video_on to the VGA DAC,
//  delayed so they line up with the one-cycle registered pixel colour.
//  Issues line/frame ticks for the game-logic update rate.
// PARAMETERS
//  PIXEL_DISPLAY_BIT  9    MSB index of X/Y (coordinate width = PIXEL_DISPLAY_BIT+1)
//  H_ACTIVE           640  visible pixels per line
//  H_FP               16   horizontal front porch, pixels
//  H_SYNC             96   hsync pulse width, pixels
//  H_BP               48   horizontal back porch, pixels
//  V_ACTIVE           480  visible lines per frame
//  V_FP               10   vertical front porch, lines
//  V_SYNC             2    vsync pulse width, lines
//  V_BP               33   vertical back porch, lines
//  SYNC_POL           0    active level of hsync/vsync (0 = active-low)
//  PIPE_DELAY         1    cycles from X/Y to hsync/vsync/video_on, legal 1..4
// PORTS
//  clock_25    in   1   25 MHz pixel clock; all logic on its rising edge
//  reset       in   1   asynchronous, active-high reset
//  X           out  10  horizontal counter, 0..H_TOTAL-1 (H_TOTAL=800)
//  Y           out  10  vertical counter, 0..V_TOTAL-1 (V_TOTAL=525)
//  hsync       out  1   horizontal sync, SYNC_POL active, delayed PIPE_DELAY
//  vsync       out  1   vertical sync, SYNC_POL active, delayed PIPE_DELAY
//  video_on    out  1   1 inside the visible window, delayed PIPE_DELAY
//  line_tick   out  1   one-cycle pulse on the last pixel of every line
//  frame_tick  out  1   one-cycle pulse on the last pixel of every frame
// BEHAVIOUR
//  - Reset (async assert, sync release): X=0, Y=0, line_tick=0,
//    frame_tick=0, video_on=0. hsync and vsync sit at ~SYNC_POL (inactive).
//    All delay stages clear to those same values.
//  - Counting: X increments every cycle. At X==H_TOTAL-1, X wraps to 0 and Y
//    increments. At X==H_TOTAL-1 and Y==V_TOTAL-1, X and Y both wrap to 0
//    on the same edge.
//  - Region order per line and per frame: active, front porch, sync, back porch.
//  - Decode rules, all comparisons unsigned:
//    hs_raw = (X >= H_ACTIVE+H_FP) && (X < H_ACTIVE+H_FP+H_SYNC)
//    vs_raw = (Y >= V_ACTIVE+V_FP) && (Y < V_ACTIVE+V_FP+V_SYNC)
//    von_raw = (X < H_ACTIVE) && (Y < V_ACTIVE)
//  - Output pipeline:
//    output(t) = decode(X(t-PIPE_DELAY), Y(t-PIPE_DELAY)).
//    The first stage is a register, so these outputs never come from a
//    combinational path.
//    hsync = hs_raw ? SYNC_POL : ~SYNC_POL; vsync is built the same way.
//  - Tick timing: line_tick and frame_tick are NOT delayed. Each is high in
//    the same cycle that X (and Y for frame_tick) shows the last position.
//    frame_tick implies line_tick.
//  - Reset mid-frame: counters and the delay line clear immediately.
//    Counting restarts at X=0,Y=0 on the first edge after release.
//    Syncs stay inactive until decode values from the new frame reach the
//    end of the delay line.
//  - Elaboration check: PIPE_DELAY outside 1..4 is a fatal error.
// STRUCTURE
//  - Shared include vga_params.vh holds the default 640x480 timing constants
//    and the derived totals H_TOTAL and V_TOTAL. background and the pixel
//    mixer use the same file.
//  - Sub-module vga_delay_line (WIDTH, DEPTH, RESET_VAL) is a parameterised
//    shift register. One instance, 3 bits wide (hs, vs, von), carries the
//    syncs and video_on.
//  - Expected size: about 150 lines plus about 40 for vga_delay_line.
// TESTING
//  1 Reset: hold reset 5 cycles -> X=0, Y=0, hsync=vsync=1, video_on=0,
//    ticks=0. Release -> X=1 one cycle later.
//  2 hsync (defaults) -> hsync low while delayed X is in 656..751, so exactly
//    96 cycles per line. The first low cycle is the cycle after X==656.
//  3 Line wrap: X=799,Y=10 -> line_tick=1, next cycle X=0,Y=11.
//    Measured line_tick period is exactly 800 cycles.
//  4 Frame: X=799,Y=524 -> frame_tick=1, next cycle X=0,Y=0.
//    frame_tick period is 420000 cycles. vsync is low for 1600 cycles.
//    video_on is high for 307200 cycles per frame.
//  5 Async reset at X=300,Y=200, pulse shorter than one clock -> outputs
//    clear without waiting for a clock edge, and counting restarts from 0,0.
//  6 PIPE_DELAY=3 -> hsync/video_on edges shift exactly 2 cycles later than
//    with PIPE_DELAY=1. X/Y and tick timing are unchanged.

Source files
------------

// File: rtl/vga_timing_gen_pkg.sv
// rtl/vga_timing_gen_pkg.sv - shared 640x480@60 timing constants and types
//
// Purpose : Default raster timing for the VGA path, the control-bit bundle
//           carried down the output delay line, and the sync-level helper.
// Ports   : none (package).

package vga_timing_gen_pkg;

  // Default 640x480@60 Hz timing, 25 MHz pixel clock.
  localparam int DEF_PIXEL_DISPLAY_BIT = 9;
  localparam int DEF_H_ACTIVE          = 640;
  localparam int DEF_H_FP              = 16;
  localparam int DEF_H_SYNC            = 96;
  localparam int DEF_H_BP              = 48;
  localparam int DEF_V_ACTIVE          = 480;
  localparam int DEF_V_FP              = 10;
  localparam int DEF_V_SYNC            = 2;
  localparam int DEF_V_BP              = 33;

  // Control bits that travel together so they stay aligned with the
  // registered pixel colour. Sync bits hold the final pin level.
  typedef struct packed {
    logic hsync;
    logic vsync;
    logic video_on;
  } vga_ctrl_t;

  // Pin level for a sync signal given whether the raw decode is active.
  function automatic logic sync_level(input logic active, input logic pol);
    return active ? pol : ~pol;
  endfunction

endpackage

// File: rtl/vga_timing_gen_if.sv
// rtl/vga_timing_gen_if.sv - raster coordinate / sync bundle
//
// Purpose : Groups the timing generator outputs for the pixel stages and DAC.
// Ports   : X, Y        pixel coordinates (CW bits)
//           hsync, vsync, video_on   delayed DAC controls
//           line_tick, frame_tick    undelayed update pulses
//           master = generator side, slave = consumers.

interface vga_timing_gen_if #(
  parameter int CW = 10
);

  logic [CW-1:0] X;
  logic [CW-1:0] Y;
  logic          hsync;
  logic          vsync;
  logic          video_on;
  logic          line_tick;
  logic          frame_tick;

  modport master (
    output X, Y, hsync, vsync, video_on, line_tick, frame_tick
  );

  modport slave (
    input X, Y, hsync, vsync, video_on, line_tick, frame_tick
  );

endinterface

// File: rtl/vga_timing_gen_delay_line.sv
// rtl/vga_timing_gen_delay_line.sv - parameterised reset-to-value shift register
//
// Purpose : Delays a WIDTH-bit word by DEPTH clock cycles; every stage is a
//           register, so dout never has a combinational path from din.
// Ports   : clk   rising-edge clock
//           rst   asynchronous active-high reset, stages load RESET_VAL
//           din   input word
//           dout  din delayed DEPTH cycles

module vga_timing_gen_delay_line #(
  parameter int               WIDTH     = 1,
  parameter int               DEPTH     = 1,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  logic [WIDTH-1:0] stage_q [DEPTH];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        stage_q[i] <= RESET_VAL;
      end
    end else begin
      stage_q[0] <= din;
      for (int i = 1; i < DEPTH; i++) begin
        stage_q[i] <= stage_q[i-1];
      end
    end
  end

  assign dout = stage_q[DEPTH-1];

endmodule

// File: rtl/vga_timing_gen.sv
// rtl/vga_timing_gen.sv - VGA raster counters, sync decode and tick generation
//
// Purpose : Counts X/Y over the full raster, decodes hsync/vsync/video_on and
//           delays them PIPE_DELAY cycles to line up with the registered pixel
//           colour. line_tick/frame_tick mark the last pixel of a line/frame
//           and are not delayed.
// Ports   : clock_25  pixel clock, rising edge
//           reset     asynchronous active-high reset
//           vga       master side of vga_timing_gen_if (X, Y, hsync, vsync,
//                     video_on, line_tick, frame_tick)

module vga_timing_gen
  import vga_timing_gen_pkg::*;
#(
  parameter int PIXEL_DISPLAY_BIT = DEF_PIXEL_DISPLAY_BIT,
  parameter int H_ACTIVE          = DEF_H_ACTIVE,
  parameter int H_FP              = DEF_H_FP,
  parameter int H_SYNC            = DEF_H_SYNC,
  parameter int H_BP              = DEF_H_BP,
  parameter int V_ACTIVE          = DEF_V_ACTIVE,
  parameter int V_FP              = DEF_V_FP,
  parameter int V_SYNC            = DEF_V_SYNC,
  parameter int V_BP              = DEF_V_BP,
  parameter bit SYNC_POL          = 1'b0,
  parameter int PIPE_DELAY        = 1
) (
  input  logic             clock_25,
  input  logic             reset,
  vga_timing_gen_if.master vga
);

  localparam int CW       = PIXEL_DISPLAY_BIT + 1;
  localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HS_START = H_ACTIVE + H_FP;
  localparam int HS_END   = HS_START + H_SYNC;
  localparam int VS_START = V_ACTIVE + V_FP;
  localparam int VS_END   = VS_START + V_SYNC;

  localparam logic [CW-1:0] H_LAST = CW'(H_TOTAL - 1);
  localparam logic [CW-1:0] V_LAST = CW'(V_TOTAL - 1);

  localparam vga_ctrl_t CTRL_IDLE = '{hsync: ~SYNC_POL, vsync: ~SYNC_POL, video_on: 1'b0};

  generate
    if (PIPE_DELAY < 1 || PIPE_DELAY > 4) begin : g_bad_pipe_delay
      $fatal(1, "vga_timing_gen: PIPE_DELAY must be in 1..4");
    end
  endgenerate

  logic [CW-1:0] x_q;
  logic [CW-1:0] y_q;
  logic          x_last;
  logic          y_last;

  assign x_last = (x_q == H_LAST);
  assign y_last = (y_q == V_LAST);

  // Raster counters: X every cycle, Y on X wrap, both wrap on the last pixel.
  always_ff @(posedge clock_25 or posedge reset) begin
    if (reset) begin
      x_q <= '0;
      y_q <= '0;
    end else if (x_last) begin
      x_q <= '0;
      y_q <= y_last ? '0 : y_q + 1'b1;
    end else begin
      x_q <= x_q + 1'b1;
    end
  end

  logic      hs_raw;
  logic      vs_raw;
  logic      von_raw;
  vga_ctrl_t ctrl_raw;
  vga_ctrl_t ctrl_dly;

  assign hs_raw  = (x_q >= CW'(HS_START)) && (x_q < CW'(HS_END));
  assign vs_raw  = (y_q >= CW'(VS_START)) && (y_q < CW'(VS_END));
  assign von_raw = (x_q < CW'(H_ACTIVE)) && (y_q < CW'(V_ACTIVE));

  // Polarity is applied before the delay line so the reset value of every
  // stage is already the inactive pin level.
  assign ctrl_raw = '{hsync:    sync_level(hs_raw, SYNC_POL),
                      vsync:    sync_level(vs_raw, SYNC_POL),
                      video_on: von_raw};

  vga_timing_gen_delay_line #(
    .WIDTH     ($bits(vga_ctrl_t)),
    .DEPTH     (PIPE_DELAY),
    .RESET_VAL (CTRL_IDLE)
  ) u_ctrl_dly (
    .clk  (clock_25),
    .rst  (reset),
    .din  (ctrl_raw),
    .dout (ctrl_dly)
  );

  assign vga.X          = x_q;
  assign vga.Y          = y_q;
  assign vga.hsync      = ctrl_dly.hsync;
  assign vga.vsync      = ctrl_dly.vsync;
  assign vga.video_on   = ctrl_dly.video_on;
  // Ticks decode straight from the counter registers so they coincide with
  // the X/Y value they mark.
  assign vga.line_tick  = x_last;
  assign vga.frame_tick = x_last && y_last;

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb/tb_vga_timing_gen.sv - directed self-checking bench for vga_timing_gen

module tb_vga_timing_gen;

  logic clk;
  logic rst;
  logic rst_s;

  int vectors = 0;
  int errors  = 0;
  int k       = 0;
  int n;
  int cnt_a;
  int cnt_b;
  int cnt_c;

  vga_timing_gen_if #(.CW(10)) if_a ();
  vga_timing_gen_if #(.CW(10)) if_b ();
  vga_timing_gen_if #(.CW(10)) if_s ();

  // Default timing, one-stage delay.
  vga_timing_gen dut_a (
    .clock_25 (clk),
    .reset    (rst),
    .vga      (if_a)
  );

  // Default timing, three-stage delay.
  vga_timing_gen #(.PIPE_DELAY(3)) dut_b (
    .clock_25 (clk),
    .reset    (rst),
    .vga      (if_b)
  );

  // Tiny raster: 16 x 8 total, 128-cycle frame.
  vga_timing_gen #(
    .H_ACTIVE (8), .H_FP (2), .H_SYNC (3), .H_BP (3),
    .V_ACTIVE (4), .V_FP (1), .V_SYNC (2), .V_BP (1),
    .PIPE_DELAY (1)
  ) dut_s (
    .clock_25 (clk),
    .reset    (rst_s),
    .vga      (if_s)
  );

  initial clk = 1'b0;
  always #20 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step_to(input int target);
    while (k < target) begin
      @(negedge clk);
      k++;
    end
  endtask

  initial begin
    rst   = 1'b1;
    rst_s = 1'b1;
    repeat (5) @(negedge clk);

    // Reset state
    chk("rst_x",      if_a.X, 0);
    chk("rst_y",      if_a.Y, 0);
    chk("rst_hsync",  if_a.hsync, 1);
    chk("rst_vsync",  if_a.vsync, 1);
    chk("rst_von",    if_a.video_on, 0);
    chk("rst_ltick",  if_a.line_tick, 0);
    chk("rst_ftick",  if_a.frame_tick, 0);
    chk("rst_b_hs",   if_b.hsync, 1);
    chk("rst_b_von",  if_b.video_on, 0);
    chk("rst_s_x",    if_s.X, 0);

    rst = 1'b0;
    k   = 0;

    step_to(1);
    chk("rel_x",      if_a.X, 1);
    chk("rel_y",      if_a.Y, 0);
    chk("rel_b_x",    if_b.X, 1);
    chk("rel_von",    if_a.video_on, 1);
    chk("rel_b_von",  if_b.video_on, 0);
    chk("rel_hsync",  if_a.hsync, 1);
    step_to(2);
    chk("b_von_k2",   if_b.video_on, 0);
    step_to(3);
    chk("b_von_k3",   if_b.video_on, 1);

    // video_on trailing edge
    step_to(640);
    chk("von_640",    if_a.video_on, 1);
    step_to(641);
    chk("von_641",    if_a.video_on, 0);
    chk("b_von_641",  if_b.video_on, 1);
    step_to(642);
    chk("b_von_642",  if_b.video_on, 1);
    step_to(643);
    chk("b_von_643",  if_b.video_on, 0);

    // hsync edges, one- and three-stage delay
    step_to(656);
    chk("hs_656",     if_a.hsync, 1);
    chk("x_656",      if_a.X, 656);
    step_to(657);
    chk("hs_657",     if_a.hsync, 0);
    chk("b_hs_657",   if_b.hsync, 1);
    step_to(658);
    chk("b_hs_658",   if_b.hsync, 1);
    step_to(659);
    chk("b_hs_659",   if_b.hsync, 0);
    step_to(752);
    chk("hs_752",     if_a.hsync, 0);
    step_to(753);
    chk("hs_753",     if_a.hsync, 1);
    chk("b_hs_753",   if_b.hsync, 0);
    step_to(754);
    chk("b_hs_754",   if_b.hsync, 0);
    step_to(755);
    chk("b_hs_755",   if_b.hsync, 1);

    // First line wrap
    step_to(799);
    chk("x_799",      if_a.X, 799);
    chk("ltick_799",  if_a.line_tick, 1);
    chk("b_ltick_799", if_b.line_tick, 1);
    chk("ftick_799",  if_a.frame_tick, 0);
    step_to(800);
    chk("wrap_x",     if_a.X, 0);
    chk("wrap_y",     if_a.Y, 1);
    chk("wrap_ltick", if_a.line_tick, 0);
    chk("b_wrap_y",   if_b.Y, 1);

    // Line wrap at Y=10
    step_to(8799);
    chk("l10_x",      if_a.X, 799);
    chk("l10_y",      if_a.Y, 10);
    chk("l10_ltick",  if_a.line_tick, 1);
    chk("l10_vsync",  if_a.vsync, 1);
    step_to(8800);
    chk("l11_x",      if_a.X, 0);
    chk("l11_y",      if_a.Y, 11);
    chk("b_l11_x",    if_b.X, 0);

    // line_tick period and hsync width over one full line
    n     = 1;
    cnt_a = (if_a.hsync == 1'b0) ? 1 : 0;
    cnt_b = (if_b.hsync == 1'b0) ? 1 : 0;
    do begin
      @(negedge clk);
      k++;
      n++;
      if (if_a.hsync == 1'b0) cnt_a++;
      if (if_b.hsync == 1'b0) cnt_b++;
    end while (!if_a.line_tick && n < 1000);
    chk("ltick_period", n, 800);
    chk("hs_low_cnt",   cnt_a, 96);
    chk("b_hs_low_cnt", cnt_b, 96);
    chk("per_end_y",    if_a.Y, 11);

    // Tiny raster: frame wrap and per-frame counts
    rst_s = 1'b0;
    k     = 0;
    step_to(1);
    chk("s_rel_x",    if_s.X, 1);
    chk("s_rel_von",  if_s.video_on, 1);
    step_to(15);
    chk("s_ltick_15", if_s.line_tick, 1);
    chk("s_ftick_15", if_s.frame_tick, 0);
    step_to(127);
    chk("s_x_127",    if_s.X, 15);
    chk("s_y_127",    if_s.Y, 7);
    chk("s_ftick",    if_s.frame_tick, 1);
    chk("s_ltick",    if_s.line_tick, 1);
    step_to(128);
    chk("s_wrap_x",   if_s.X, 0);
    chk("s_wrap_y",   if_s.Y, 0);
    chk("s_wrap_ft",  if_s.frame_tick, 0);

    n     = 1;
    cnt_a = (if_s.vsync == 1'b0) ? 1 : 0;
    cnt_b = (if_s.video_on == 1'b1) ? 1 : 0;
    cnt_c = (if_s.hsync == 1'b0) ? 1 : 0;
    do begin
      @(negedge clk);
      k++;
      n++;
      if (if_s.vsync == 1'b0)    cnt_a++;
      if (if_s.video_on == 1'b1) cnt_b++;
      if (if_s.hsync == 1'b0)    cnt_c++;
    end while (!if_s.frame_tick && n < 200);
    chk("s_ftick_period", n, 128);
    chk("s_vs_low_cnt",   cnt_a, 32);
    chk("s_von_cnt",      cnt_b, 32);
    chk("s_hs_low_cnt",   cnt_c, 24);

    // Async reset mid-frame while both syncs are active
    step_to(347);
    chk("s_mid_x",    if_s.X, 11);
    chk("s_mid_y",    if_s.Y, 5);
    chk("s_mid_hs",   if_s.hsync, 0);
    chk("s_mid_vs",   if_s.vsync, 0);
    #5 rst_s = 1'b1;
    #3;
    chk("s_arst_x",   if_s.X, 0);
    chk("s_arst_y",   if_s.Y, 0);
    chk("s_arst_hs",  if_s.hsync, 1);
    chk("s_arst_vs",  if_s.vsync, 1);
    chk("s_arst_von", if_s.video_on, 0);
    #2 rst_s = 1'b0;
    @(negedge clk);
    chk("s_rst_x",    if_s.X, 1);
    chk("s_rst_y",    if_s.Y, 0);
    chk("s_rst_von",  if_s.video_on, 1);
    chk("s_rst_hs",   if_s.hsync, 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
